fusion_unit_pipe: RTL and testbench

//  Bit-fusion MAC processing element with weight precision selectable per beat (DATA_W, DATA_W/2, 2 bits).

---
 rtl/fusion_pkg.sv | 30 +++
 rtl/fusion_lane_mac.sv | 26 ++
 rtl/fusion_unit_pipe.sv | 123 ++++++++++++
 tb/tb_fusion_unit_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
// Shared definitions for the bit-fusion MAC processing element.
// Weight precision modes, their one-hot width codes and the decoder.
package fusion_pkg;

    typedef enum logic [1:0] {
        MODE_FULL = 2'd0,
        MODE_HALF = 2'd1,
        MODE_2B   = 2'd2
    } mode_t;

    localparam logic [3:0] WW_FULL = 4'b1000;
    localparam logic [3:0] WW_HALF = 4'b0100;
    localparam logic [3:0] WW_2B   = 4'b0010;

    function automatic logic ww_legal(input logic [3:0] ww);
        return (ww == WW_FULL) || (ww == WW_HALF) || (ww == WW_2B);
    endfunction

    // Anything that is not a legal code falls back to the narrowest mode.
    function automatic mode_t ww_decode(input logic [3:0] ww);
        mode_t m;
        case (ww)
            WW_FULL: m = MODE_FULL;
            WW_HALF: m = MODE_HALF;
            default: m = MODE_2B;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fusion_lane_mac.sv
// One weight-slice multiply: extends activation and slice by their
// sign flags, multiplies exactly and resizes the product to the lane width.
module fusion_lane_mac #(
    parameter int DATA_W = 8,
    parameter int W      = 2,
    parameter int P      = 13
) (
    input  logic [DATA_W-1:0] a,
    input  logic              s_a,
    input  logic [W-1:0]      b,
    input  logic              s_b,
    output logic [P-1:0]      prod
);

    localparam int PW = DATA_W + W + 2;

    logic signed [DATA_W:0] a_x;
    logic signed [W:0]      b_x;
    logic signed [PW-1:0]   p_x;

    assign a_x  = {s_a & a[DATA_W-1], a};
    assign b_x  = {s_b & b[W-1], b};
    assign p_x  = PW'(a_x) * PW'(b_x);
    assign prod = P'(p_x);

endmodule

// File: rtl/fusion_unit_pipe.sv
// Elastic two-stage bit-fusion MAC PE with per-beat weight precision.
// S1 holds products of every mode; S2 selects by mode and accumulates.
module fusion_unit_pipe
    import fusion_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COL_WIDTH = 13
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in,
    input  logic [DATA_W-1:0]                 weight,
    input  logic [COL_WIDTH*(DATA_W/2)-1:0]   psum_in,
    input  logic [3:0]                        weight_width,
    input  logic                              s_in,
    input  logic                              s_weight,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [COL_WIDTH*(DATA_W/2)-1:0]   psum_fwd,
    output logic                              mode_err
);

    localparam int LANES  = DATA_W / 2;
    localparam int PSUM_W = COL_WIDTH * LANES;
    localparam int HALF_W = DATA_W / 2;
    localparam int HALF_P = PSUM_W / 2;

    mode_t              in_mode;
    mode_t              s1_mode;
    logic               s1_valid;
    logic               s2_adv;
    logic               busy;
    logic               accept;
    logic [PSUM_W-1:0]  p_full, p_half, p_2b;
    logic [PSUM_W-1:0]  s1_psum, s1_full, s1_half, s1_2b;
    logic [PSUM_W-1:0]  sum;

    assign in_mode = ww_decode(weight_width);
    assign s2_adv  = s1_valid && (!out_valid || out_ready);
    assign busy    = s1_valid || out_valid;

    // All in-flight beats share s1_mode; a new mode waits for an empty pipe.
    assign in_ready = (!s1_valid || s2_adv) && (!busy || (in_mode == s1_mode));
    assign accept   = in_valid && in_ready;

    fusion_lane_mac #(.DATA_W(DATA_W), .W(DATA_W), .P(PSUM_W)) u_full (
        .a(in), .s_a(s_in), .b(weight), .s_b(s_weight), .prod(p_full)
    );

    for (genvar k = 0; k < 2; k++) begin : g_half
        fusion_lane_mac #(.DATA_W(DATA_W), .W(HALF_W), .P(HALF_P)) u_mac (
            .a(in), .s_a(s_in),
            .b(weight[k*HALF_W +: HALF_W]), .s_b(s_weight),
            .prod(p_half[k*HALF_P +: HALF_P])
        );
    end

    for (genvar k = 0; k < LANES; k++) begin : g_2b
        fusion_lane_mac #(.DATA_W(DATA_W), .W(2), .P(COL_WIDTH)) u_mac (
            .a(in), .s_a(s_in),
            .b(weight[k*2 +: 2]), .s_b(s_weight),
            .prod(p_2b[k*COL_WIDTH +: COL_WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_2B;
            s1_psum  <= '0;
            s1_full  <= '0;
            s1_half  <= '0;
            s1_2b    <= '0;
            mode_err <= 1'b0;
        end else begin
            mode_err <= accept && !ww_legal(weight_width);
            if (accept) begin
                s1_valid <= 1'b1;
                s1_mode  <= in_mode;
                s1_psum  <= psum_in;
                s1_full  <= p_full;
                s1_half  <= p_half;
                s1_2b    <= p_2b;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        sum = '0;
        case (s1_mode)
            MODE_FULL: sum = s1_psum + s1_full;
            MODE_HALF: begin
                for (int k = 0; k < 2; k++) begin
                    sum[k*HALF_P +: HALF_P] =
                        s1_psum[k*HALF_P +: HALF_P] + s1_half[k*HALF_P +: HALF_P];
                end
            end
            default: begin
                for (int k = 0; k < LANES; k++) begin
                    sum[k*COL_WIDTH +: COL_WIDTH] =
                        s1_psum[k*COL_WIDTH +: COL_WIDTH] + s1_2b[k*COL_WIDTH +: COL_WIDTH];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            psum_fwd  <= '0;
        end else if (s2_adv) begin
            out_valid <= 1'b1;
            psum_fwd  <= sum;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fusion_unit_pipe.sv
// Directed bench for fusion_unit_pipe with an arithmetic reference model
// and a scoreboard checked on every negative clock edge.
module tb_fusion_unit_pipe;

    localparam logic [3:0] WF = 4'b1000;
    localparam logic [3:0] WH = 4'b0100;
    localparam logic [3:0] W2 = 4'b0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in;
    logic [7:0]  weight;
    logic [51:0] psum_in;
    logic [3:0]  weight_width;
    logic        s_in;
    logic        s_weight;
    logic        out_valid;
    logic        out_ready;
    logic [51:0] psum_fwd;
    logic        mode_err;

    int vectors     = 0;
    int miscompares = 0;
    int acc_cnt     = 0;
    int err_cnt     = 0;
    logic        err_pend = 1'b0;
    logic        held_v   = 1'b0;
    logic [51:0] held;
    logic [51:0] exp_q[$];
    logic [51:0] got[$];

    always #5 clk = ~clk;

    fusion_unit_pipe #(.DATA_W(8), .COL_WIDTH(13)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in(in), .weight(weight), .psum_in(psum_in),
        .weight_width(weight_width), .s_in(s_in), .s_weight(s_weight),
        .out_valid(out_valid), .out_ready(out_ready),
        .psum_fwd(psum_fwd), .mode_err(mode_err)
    );

    function automatic bit legal(input logic [3:0] ww);
        return ww == WF || ww == WH || ww == W2;
    endfunction

    function automatic logic [51:0] model(input logic [3:0] ww, input logic [7:0] a,
                                          input logic [7:0] w, input logic [51:0] ps,
                                          input logic sa, input logic sw);
        int wb, p;
        longint av, sv;
        logic [63:0] mask, lane;
        logic [51:0] r;
        wb = (ww == WF) ? 8 : (ww == WH) ? 4 : 2;
        p = 13 * wb / 2;
        mask = (64'd1 << p) - 64'd1;
        av = longint'(a);
        if (sa && a[7]) av -= 256;
        r = '0;
        for (int k = 0; k < 8 / wb; k++) begin
            sv = longint'((w >> (k * wb)) & ((8'd1 << wb) - 8'd1));
            if (sw && sv >= (longint'(1) << (wb - 1))) sv -= longint'(1) << wb;
            lane = ({12'd0, ps} >> (k * p)) & mask;
            lane = (lane + 64'(av * sv)) & mask;
            r = r | 52'(lane << (k * p));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            err_pend = 1'b0;
            held_v   = 1'b0;
        end else begin
            check("mode_err", 64'(mode_err), 64'(err_pend));
            if (held_v) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'(psum_fwd), 64'(held));
            end
            held_v = out_valid && !out_ready;
            held   = psum_fwd;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_out: got %0h expected no beat", psum_fwd);
                end else begin
                    got.push_back(psum_fwd);
                    check("psum_fwd", 64'(psum_fwd), 64'(exp_q.pop_front()));
                end
            end
            if (mode_err) err_cnt++;
            err_pend = in_valid && in_ready && !legal(weight_width);
            if (in_valid && in_ready) begin
                acc_cnt++;
                exp_q.push_back(model(weight_width, in, weight, psum_in, s_in, s_weight));
            end
        end
    end

    task automatic send(input logic [3:0] ww, input logic [7:0] a, input logic [7:0] w,
                        input logic [51:0] ps, input logic sa, input logic sw,
                        output int waits);
        waits = 0;
        weight_width = ww; in = a; weight = w; psum_in = ps;
        s_in = sa; s_weight = sw; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
        end
        if (waits >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int w, base, c0, e0;
        rst = 1'b1; in_valid = 1'b0; in = '0; weight = '0; psum_in = '0;
        weight_width = W2; s_in = 1'b0; s_weight = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_psum_fwd", 64'(psum_fwd), 64'd0);
        check("rst_mode_err", 64'(mode_err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        base = got.size();
        send(WF, 8'hFD, 8'h05, 52'd100, 1'b1, 1'b1, w);
        check("lat1_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat2_valid", 64'(out_valid), 64'd1);
        check("lat2_psum", 64'(psum_fwd), 64'd85);
        drain();
        check("full_pin", 64'(got[base]), 64'd85);

        base = got.size();
        send(WH, 8'd2, 8'h3F, 52'd0, 1'b0, 1'b1, w);
        drain();
        check("half_pin", 64'(got[base]), 64'({26'd6, 26'h3FFFFFE}));

        base = got.size();
        send(W2, 8'd10, 8'b11_10_01_00, 52'd0, 1'b0, 1'b0, w);
        drain();
        check("2b_pin", 64'(got[base]), 64'({13'd30, 13'd20, 13'd10, 13'd0}));

        base = got.size();
        send(W2, 8'd3, 8'h03, {39'd0, 13'h1FFF}, 1'b0, 1'b0, w);
        send(W2, 8'h80, 8'hB4, 52'h0_1234_5678_9ABC, 1'b1, 1'b1, w);
        check("stream_wait0", 64'(w), 64'd0);
        send(W2, 8'h7F, 8'h6C, 52'h8_7654_3210_FEDC, 1'b0, 1'b1, w);
        check("stream_wait1", 64'(w), 64'd0);
        drain();
        check("2b_wrap_pin", 64'(got[base]), 64'({39'd0, 13'd8}));

        base = got.size();
        send(WF, 8'd1, 8'd1, 52'hF_FFFF_FFFF_FFFF, 1'b0, 1'b0, w);
        send(WF, 8'h81, 8'hC3, 52'h0_0000_0000_1000, 1'b1, 1'b0, w);
        send(WH, 8'hF0, 8'h9E, 52'h1_5555_2AAA_AAAA, 1'b1, 1'b1, w);
        drain();
        check("full_wrap_pin", 64'(got[base]), 64'd0);

        base = got.size();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(WF, 8'd1, 8'(i + 1), 52'd0, 1'b0, 1'b0, w);
            end
            begin
                c0 = acc_cnt;
                repeat (3) @(posedge clk);
                #1;
                check("bp_accepts", 64'(acc_cnt - c0), 64'd2);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(got.size() - base), 64'd4);
        for (int i = 0; i < 4; i++)
            if (got.size() > base + i) check("bp_order", 64'(got[base + i]), 64'(i + 1));

        base = got.size();
        send(WF, 8'd1, 8'd7, 52'd0, 1'b0, 1'b0, w);
        send(WH, 8'd2, 8'h21, 52'd0, 1'b0, 1'b0, w);
        check("mode_change_wait", 64'(w), 64'd2);
        drain();
        check("mode_change_half", 64'(got[base + 1]), 64'({26'd4, 26'd2}));

        base = got.size();
        e0 = err_cnt;
        send(4'b0011, 8'd10, 8'b11_10_01_00, 52'd0, 1'b0, 1'b0, w);
        drain();
        check("illegal_pulses", 64'(err_cnt - e0), 64'd1);
        check("illegal_2b", 64'(got[base]), 64'({13'd30, 13'd20, 13'd10, 13'd0}));

        base = got.size();
        out_ready = 1'b0;
        send(W2, 8'd5, 8'h55, 52'd7, 1'b0, 1'b0, w);
        send(W2, 8'd6, 8'hAA, 52'd9, 1'b0, 1'b0, w);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_psum", 64'(psum_fwd), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_none", 64'(got.size() - base), 64'd0);
        send(W2, 8'd10, 8'b11_10_01_00, {13'd1, 13'd1, 13'd1, 13'd1}, 1'b0, 1'b0, w);
        drain();
        check("post_rst_pin", 64'(got[base]), 64'({13'd31, 13'd21, 13'd11, 13'd1}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
